// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: handshake bundle between the issue controller and its
// neighbours.
//   Instruction channel : instr_valid/instr_ready, instr, rs_data, rt_data
//   Result channel      : result_valid/result_ready, result_data,
//                         result_dest, result_we, result_status
// Modports:
//   master : environment side (decode/operand fetch producer + writeback)
//   slave  : the issue controller
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              result_valid;
    logic              result_ready;
    logic [DATA_W-1:0] result_data;
    logic [REG_AW-1:0] result_dest;
    logic              result_we;
    logic [1:0]        result_status;

    modport master (
        output instr_valid, instr, rs_data, rt_data, result_ready,
        input  instr_ready, result_valid, result_data, result_dest,
               result_we, result_status
    );

    modport slave (
        input  instr_valid, instr, rs_data, rt_data, result_ready,
        output instr_ready, result_valid, result_data, result_dest,
               result_we, result_status
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue-side controller for the registered 32-bit ALU.
// Accepts R-type instructions with operands, drives the ALU for one cycle,
// captures its result one cycle later and returns a tagged response to
// writeback. Owns the HI/LO registers (mult/div write LO, clear HI).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   io (slave)    : instruction and result handshakes
//   alu_a/b/ctrl  : ALU operands and select (registered, held between ops)
//   alu_result    : registered ALU output, valid in WAIT
//   hi, lo        : special registers
module alu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                clk,
    input  logic                rst,
    alu_issue_ctrl_if.slave     io,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [2:0]          alu_ctrl,
    input  logic [DATA_W-1:0]   alu_result,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo
);
    typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_ILL  = 2'b01;
    localparam logic [1:0] ST_DIV0 = 2'b10;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]        alu_ctrl_q, alu_ctrl_d;
    logic              muldiv_q, muldiv_d;   // in-flight op targets HI/LO
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [REG_AW-1:0] rdest_q, rdest_d;
    logic              rwe_q, rwe_d;
    logic [1:0]        rstat_q, rstat_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

    // Decode
    logic [5:0]        op, funct;
    logic [REG_AW-1:0] rd;
    logic              dec_alu, dec_muldiv, dec_div, dec_mfhi, dec_mflo;
    logic [2:0]        dec_ctrl;

    assign op    = io.instr[31:26];
    assign funct = io.instr[5:0];
    assign rd    = REG_AW'(io.instr[15:11]);

    // Register indices and shamt are resolved upstream; operands arrive by value.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{io.instr[25:16], io.instr[10:6]};

    always_comb begin
        dec_alu    = 1'b0;
        dec_muldiv = 1'b0;
        dec_div    = 1'b0;
        dec_mfhi   = 1'b0;
        dec_mflo   = 1'b0;
        dec_ctrl   = 3'b000;
        if (op == 6'h00) begin
            case (funct)
                6'h20: begin dec_alu = 1'b1; dec_ctrl = 3'b000; end
                6'h22: begin dec_alu = 1'b1; dec_ctrl = 3'b001; end
                6'h24: begin dec_alu = 1'b1; dec_ctrl = 3'b010; end
                6'h25: begin dec_alu = 1'b1; dec_ctrl = 3'b011; end
                6'h2A: begin dec_alu = 1'b1; dec_ctrl = 3'b100; end
                6'h18: begin dec_alu = 1'b1; dec_muldiv = 1'b1; dec_ctrl = 3'b101; end
                6'h1A: begin dec_alu = 1'b1; dec_muldiv = 1'b1; dec_div = 1'b1; dec_ctrl = 3'b110; end
                6'h10: dec_mfhi = 1'b1;
                6'h12: dec_mflo = 1'b1;
                default: ;
            endcase
        end
    end

    // FSM next state / datapath
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctrl_d = alu_ctrl_q;
        muldiv_d   = muldiv_q;
        rdata_d    = rdata_q;
        rdest_d    = rdest_q;
        rwe_d      = rwe_q;
        rstat_d    = rstat_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            IDLE: begin
                if (io.instr_valid) begin
                    rdest_d = rd;
                    if (dec_div && io.rt_data == '0) begin
                        // ALU never issued; HI/LO untouched
                        rdata_d = '0;
                        rwe_d   = 1'b0;
                        rstat_d = ST_DIV0;
                        state_d = RESP;
                    end else if (dec_alu) begin
                        alu_a_d    = io.rs_data;
                        alu_b_d    = io.rt_data;
                        alu_ctrl_d = dec_ctrl;
                        muldiv_d   = dec_muldiv;
                        state_d    = EXEC;
                    end else if (dec_mfhi || dec_mflo) begin
                        rdata_d = dec_mfhi ? hi_q : lo_q;
                        rwe_d   = (rd != '0);
                        rstat_d = ST_OK;
                        state_d = RESP;
                    end else begin
                        rdata_d = '0;
                        rwe_d   = 1'b0;
                        rstat_d = ST_ILL;
                        state_d = RESP;
                    end
                end
            end
            EXEC: state_d = WAIT;
            WAIT: begin
                rdata_d = alu_result;
                rstat_d = ST_OK;
                if (muldiv_q) begin
                    // Only the low word is produced by the ALU
                    lo_d  = alu_result;
                    hi_d  = '0;
                    rwe_d = 1'b0;
                end else begin
                    rwe_d = (rdest_q != '0);
                end
                state_d = RESP;
            end
            RESP: if (io.result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= 3'b000;
            muldiv_q   <= 1'b0;
            rdata_q    <= '0;
            rdest_q    <= '0;
            rwe_q      <= 1'b0;
            rstat_q    <= ST_OK;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
            muldiv_q   <= muldiv_d;
            rdata_q    <= rdata_d;
            rdest_q    <= rdest_d;
            rwe_q      <= rwe_d;
            rstat_q    <= rstat_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign io.instr_ready   = (state_q == IDLE);
    assign io.result_valid  = (state_q == RESP);
    assign io.result_data   = rdata_q;
    assign io.result_dest   = rdest_q;
    assign io.result_we     = rwe_q;
    assign io.result_status = rstat_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_ctrl = alu_ctrl_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule
